// File: rtl/video_frame_monitor.sv
// Frame monitor: tracks pixel coordinates of a sof/eol framed video stream, flags framing errors, counts frames.
// Latency: one pixclk from accepted pixel to pix_valid/pix_data/coords/line_done/frame_done.
// Backpressure: none; every valid beat is sampled. Optional per-frame checksum under FRAME_CHECKSUM_EN.
module video_frame_monitor #(
    parameter int IMG_WIDTH  = 1920,
    parameter int IMG_HEIGHT = 1080,
    parameter int NUM_CH     = 3,
    parameter int CH_BITS    = 8
) (
    input  logic                      pixclk,
    input  logic                      reset,
    input  logic                      valid,
    input  logic                      sof,
    input  logic                      eol,
    input  logic [NUM_CH*CH_BITS-1:0] iData,
    input  logic                      clr_err,
    output logic                      pix_valid,
    output logic [NUM_CH*CH_BITS-1:0] pix_data,
    output logic [15:0]               x_coord,
    output logic [15:0]               y_coord,
    output logic                      line_done,
    output logic                      frame_done,
    output logic                      busy,
    output logic [3:0]                err_flags,
    output logic [15:0]               frame_count,
    output logic [31:0]               checksum
);

    localparam logic [15:0] X_LAST = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(IMG_HEIGHT - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t      state, state_nxt;
    logic [15:0] nx, ny;          // position the next non-sof pixel will take
    logic [15:0] nx_nxt, ny_nxt;
    logic [15:0] cx, cy;          // position of the pixel presented this cycle
    logic        accept;
    logic        line_end;
    logic        frame_end;
    logic [3:0]  err_det;         // {STRAY, SOF_RESTART, MISSING_EOL, EARLY_EOL}

    // Next-state, pixel acceptance, position and error detection
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        cx        = nx;
        cy        = ny;
        line_end  = 1'b0;
        frame_end = 1'b0;
        nx_nxt    = nx;
        ny_nxt    = ny;
        err_det   = 4'b0000;
        if (valid) begin
            if (sof) begin
                // sof always (re)starts a frame at the origin
                accept = 1'b1;
                cx     = 16'd0;
                cy     = 16'd0;
                if (state == ACTIVE) begin
                    err_det[2] = 1'b1;
                end
            end else if (state == ACTIVE) begin
                accept = 1'b1;
            end else begin
                err_det[3] = 1'b1;
            end
        end
        if (accept) begin
            line_end   = eol | (cx == X_LAST);
            frame_end  = line_end & (cy == Y_LAST);
            err_det[0] = eol & (cx < X_LAST);
            err_det[1] = ~eol & (cx == X_LAST);
            if (line_end) begin
                nx_nxt = 16'd0;
                ny_nxt = cy + 16'd1;
            end else begin
                nx_nxt = cx + 16'd1;
                ny_nxt = cy;
            end
            state_nxt = frame_end ? IDLE : ACTIVE;
        end
    end

    assign busy = (state == ACTIVE);

    // State and expected-position registers
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            nx    <= 16'd0;
            ny    <= 16'd0;
        end else begin
            state <= state_nxt;
            nx    <= nx_nxt;
            ny    <= ny_nxt;
        end
    end

    // Registered pixel report, pulses and frame counter; coords hold between pixels
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            x_coord     <= 16'd0;
            y_coord     <= 16'd0;
            line_done   <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            pix_valid  <= accept;
            line_done  <= accept & line_end;
            frame_done <= accept & frame_end;
            if (accept) begin
                pix_data <= iData;
                x_coord  <= cx;
                y_coord  <= cy;
            end
            if (accept && frame_end) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    // Sticky errors: a fresh detection outranks a simultaneous clear
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            err_flags <= 4'b0000;
        end else begin
            err_flags <= (clr_err ? 4'b0000 : err_flags) | err_det;
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [31:0] acc;
    logic [31:0] pix_sum;
    logic [31:0] acc_nxt;

    // Modulo-2^32 sum of the channel fields of the current pixel
    always_comb begin
        pix_sum = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            pix_sum = pix_sum + 32'(iData[i*CH_BITS +: CH_BITS]);
        end
        acc_nxt = (sof ? 32'd0 : acc) + pix_sum;
    end

    // Accumulate accepted pixels; publish the total on the frame's last pixel
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            acc      <= 32'd0;
            checksum <= 32'd0;
        end else if (accept) begin
            acc <= acc_nxt;
            if (frame_end) begin
                checksum <= acc_nxt;
            end
        end
    end
`else
    assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_video_frame_monitor.sv
module tb_video_frame_monitor;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int NC = 3;
    localparam int CB = 8;
`ifdef FRAME_CHECKSUM_EN
    localparam logic [31:0] CS_S1 = 32'd48;
`else
    localparam logic [31:0] CS_S1 = 32'd0;
`endif

    logic                pixclk  = 1'b0;
    logic                reset   = 1'b1;
    logic                valid   = 1'b0;
    logic                sof     = 1'b0;
    logic                eol     = 1'b0;
    logic                clr_err = 1'b0;
    logic [NC*CB-1:0]    iData   = '0;
    logic                pix_valid;
    logic [NC*CB-1:0]    pix_data;
    logic [15:0]         x_coord, y_coord;
    logic                line_done, frame_done, busy;
    logic [3:0]          err_flags;
    logic [15:0]         frame_count;
    logic [31:0]         checksum;

    video_frame_monitor #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .NUM_CH(NC), .CH_BITS(CB)
    ) dut (
        .pixclk(pixclk), .reset(reset), .valid(valid), .sof(sof), .eol(eol),
        .iData(iData), .clr_err(clr_err), .pix_valid(pix_valid), .pix_data(pix_data),
        .x_coord(x_coord), .y_coord(y_coord), .line_done(line_done),
        .frame_done(frame_done), .busy(busy), .err_flags(err_flags),
        .frame_count(frame_count), .checksum(checksum)
    );

    always #5 pixclk = ~pixclk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    int ld_cnt   = 0;
    int fd_cnt   = 0;

    // Reference model: frame position, running sum and expected outputs
    bit          m_active = 1'b0;
    int          m_x = 0, m_y = 0;
    logic [31:0] m_sum = '0;
    logic        exp_pv = 1'b0, exp_ld = 1'b0, exp_fd = 1'b0;
    logic [23:0] exp_pd = '0;
    logic [15:0] exp_x = '0, exp_y = '0, exp_fc = '0;
    logic [3:0]  exp_err = '0;
    logic [31:0] exp_cs = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] chsum(input logic [23:0] d);
        return 32'(d[23:16]) + 32'(d[15:8]) + 32'(d[7:0]);
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_x = 0; m_y = 0; m_sum = '0;
        exp_pv = 1'b0; exp_ld = 1'b0; exp_fd = 1'b0; exp_pd = '0;
        exp_x = '0; exp_y = '0; exp_fc = '0; exp_err = '0; exp_cs = '0;
    endtask

    task automatic model_step();
        bit       acc = 1'b0;
        int       px = m_x;
        int       py = m_y;
        logic [3:0] ne = 4'b0000;
        exp_pv = 1'b0; exp_ld = 1'b0; exp_fd = 1'b0;
        if (valid) begin
            if (sof) begin
                if (m_active) ne[2] = 1'b1;
                px = 0; py = 0; m_sum = '0; acc = 1'b1;
            end else if (m_active) begin
                acc = 1'b1;
            end else begin
                ne[3] = 1'b1;
            end
        end
        if (acc) begin
            m_sum  = m_sum + chsum(iData);
            exp_pv = 1'b1; exp_pd = iData; exp_x = 16'(px); exp_y = 16'(py);
            if (eol && px < W - 1) ne[0] = 1'b1;
            if (!eol && px == W - 1) ne[1] = 1'b1;
            m_active = 1'b1;
            if (eol || px == W - 1) begin
                exp_ld = 1'b1; m_x = 0; m_y = py + 1;
                if (py == H - 1) begin
                    exp_fd = 1'b1; exp_fc = exp_fc + 16'd1; m_active = 1'b0;
`ifdef FRAME_CHECKSUM_EN
                    exp_cs = m_sum;
`endif
                end
            end else begin
                m_x = px + 1; m_y = py;
            end
        end
        exp_err = (clr_err ? 4'b0000 : exp_err) | ne;
    endtask

    task automatic compare_all();
        check("pix_valid", pix_valid, exp_pv);
        if (exp_pv) check("pix_data", pix_data, exp_pd);
        check("x_coord", x_coord, exp_x);
        check("y_coord", y_coord, exp_y);
        check("line_done", line_done, exp_ld);
        check("frame_done", frame_done, exp_fd);
        check("busy", busy, m_active);
        check("err_flags", err_flags, exp_err);
        check("frame_count", frame_count, exp_fc);
        check("checksum", checksum, exp_cs);
        if (line_done) ld_cnt++;
        if (frame_done) fd_cnt++;
    endtask

    // Model advances with the DUT and follows the asynchronous reset
    always @(posedge pixclk or negedge reset) begin
        if (!reset) model_reset();
        else model_step();
    end

    // Compare every output against the model mid-cycle
    always @(negedge pixclk) begin
        if (chk_en) compare_all();
    end

    task automatic tick();
        @(posedge pixclk);
        #1;
    endtask

    task automatic px_in(input bit s, input bit e, input logic [23:0] d);
        valid = 1'b1; sof = s; eol = e; iData = d;
        tick();
        valid = 1'b0; sof = 1'b0; eol = 1'b0;
    endtask

    task automatic idle(input int n);
        valid = 1'b0; sof = 1'b0; eol = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_errors();
        clr_err = 1'b1; idle(1); clr_err = 1'b0;
    endtask

    initial begin
        logic [15:0] fcb;
        #2 reset = 1'b0;
        #10;
        check("rst_pix_valid", pix_valid, 0);
        check("rst_x", x_coord, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_err", err_flags, 0);
        check("rst_busy", busy, 0);
        check("rst_checksum", checksum, 0);
        @(posedge pixclk);
        #3 reset = 1'b1;
        chk_en = 1'b1;
        tick();

        // Clean 4x2 frame, constant pixel value
        ld_cnt = 0; fd_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            px_in(k == 0, k == 3 || k == 7, 24'h010203);
            check("s1_line_done", line_done, (k == 3 || k == 7));
            check("s1_frame_done", frame_done, (k == 7));
        end
        idle(1);
        check("s1_frame_count", frame_count, 1);
        check("s1_err", err_flags, 0);
        check("s1_busy", busy, 0);
        check("s1_checksum", checksum, CS_S1);
        check("s1_ld_cnt", ld_cnt, 2);
        check("s1_fd_cnt", fd_cnt, 1);

        // Early eol on pixel 1
        px_in(1, 0, 24'($urandom));
        px_in(0, 1, 24'($urandom));
        check("s2_err", err_flags, 4'b0001);
        px_in(0, 0, 24'($urandom));
        check("s2_x", x_coord, 0);
        check("s2_y", y_coord, 1);
        px_in(0, 0, 24'($urandom));
        px_in(0, 0, 24'($urandom));
        px_in(0, 1, 24'($urandom));
        check("s2_frame_count", frame_count, 2);
        clear_errors();
        check("s2_clr", err_flags, 0);

        // sof restart mid-frame
        fcb = frame_count; fd_cnt = 0;
        px_in(1, 0, 24'($urandom));
        px_in(0, 0, 24'($urandom));
        px_in(0, 0, 24'($urandom));
        px_in(0, 1, 24'($urandom));
        px_in(0, 0, 24'($urandom));
        px_in(1, 0, 24'($urandom));
        check("s3_x", x_coord, 0);
        check("s3_y", y_coord, 0);
        check("s3_err2", err_flags[2], 1);
        check("s3_fc_hold", frame_count, fcb);
        for (int j = 1; j <= 7; j++) begin
            px_in(0, j == 3 || j == 7, 24'($urandom));
            if (j < 7) check("s3_no_fd", fd_cnt, 0);
        end
        idle(1);
        check("s3_fd_cnt", fd_cnt, 1);
        check("s3_frame_count", frame_count, fcb + 16'd1);
        clear_errors();

        // Stray pixel in IDLE, clear collision, then clear
        idle(1);
        px_in(0, 0, 24'($urandom));
        check("s4_pix_valid", pix_valid, 0);
        check("s4_err", err_flags, 4'b1000);
        clr_err = 1'b1;
        px_in(0, 0, 24'($urandom));
        check("s4_clr_vs_err", err_flags, 4'b1000);
        idle(1);
        clr_err = 1'b0;
        check("s4_cleared", err_flags, 0);

        // Randomised traffic with occasional asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                valid = 1'b0;
                #2 reset = 1'b0;
                tick();
                #2 reset = 1'b1;
            end
            valid   = ($urandom_range(0, 4) != 0);
            sof     = m_active ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 2) == 0);
            eol     = (m_x == W - 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
            clr_err = ($urandom_range(0, 15) == 0);
            iData   = 24'($urandom);
            tick();
        end
        clr_err = 1'b0;
        idle(2);

        // Reset asserted after pixel 2 of a frame
        fd_cnt = 0;
        px_in(1, 0, 24'($urandom));
        px_in(0, 0, 24'($urandom));
        px_in(0, 0, 24'($urandom));
        #2 reset = 1'b0;
        #1;
        check("s6_pix_valid", pix_valid, 0);
        check("s6_x", x_coord, 0);
        check("s6_frame_count", frame_count, 0);
        check("s6_busy", busy, 0);
        check("s6_err", err_flags, 0);
        tick();
        #2 reset = 1'b1;
        tick();
        check("s6_no_fd", fd_cnt, 0);
        for (int k = 0; k < 8; k++) px_in(k == 0, k == 3 || k == 7, 24'($urandom));
        idle(1);
        check("s6_fc_after", frame_count, 1);
        check("s6_err_after", err_flags, 0);
        check("s6_fd_cnt", fd_cnt, 1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
